// File: rtl/feed_scheduler.sv
// ============================================================================
// feed_scheduler : portion-feeding sequencer (timer wait, motor run, sensor count)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module feed_scheduler #(
  parameter logic [31:0] MOTOR_MAX_CYCLES = 32'd100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       clear,
  input  logic [2:0] portions_in,
  input  logic       timer_done,
  input  logic       sensor_on,
  output logic       timer_load,
  output logic       timer_en,
  output logic       motor_on,
  output logic [2:0] portions_left,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COUNT = 3'd2,
    S_FEED  = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  left_q, left_d;
  logic [31:0] cnt_q, cnt_d;
  logic        sync1_q, sync2_q, dly_q;
  logic        timer_load_q, timer_en_q, motor_on_q, busy_q, done_q, fault_q;
  logic        w_rise;
  logic        w_timeout;

  assign w_rise    = sync2_q & ~dly_q;
  assign w_timeout = (cnt_q == (MOTOR_MAX_CYCLES - 32'd1));

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    cnt_d   = (state_q == S_FEED) ? (cnt_q + 32'd1) : 32'd0;
    if (state_q == S_IDLE) begin
      if (!abort && start && (portions_in != 3'd0)) begin
        left_d  = portions_in;
        state_d = S_LOAD;
      end
    end else if (abort) begin
      state_d = S_IDLE;
      left_d  = 3'd0;
    end else begin
      case (state_q)
        S_LOAD:  state_d = S_COUNT;
        S_COUNT: if (timer_done) state_d = S_FEED;
        S_FEED: begin
          // A sensor edge beats a coincident timeout
          if (w_rise) begin
            left_d  = left_q - 3'd1;
            state_d = (left_q == 3'd1) ? S_DONE : S_LOAD;
          end else if (w_timeout) begin
            state_d = S_FAULT;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_FAULT: begin
          if (clear) begin
            state_d = S_IDLE;
            left_d  = 3'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered decodes of the next state so they track state_q exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      left_q       <= 3'd0;
      cnt_q        <= 32'd0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      dly_q        <= 1'b0;
      timer_load_q <= 1'b0;
      timer_en_q   <= 1'b0;
      motor_on_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      left_q       <= left_d;
      cnt_q        <= cnt_d;
      sync1_q      <= sensor_on;
      sync2_q      <= sync1_q;
      dly_q        <= sync2_q;
      timer_load_q <= (state_d == S_LOAD);
      timer_en_q   <= (state_d == S_COUNT);
      motor_on_q   <= (state_d == S_FEED);
      busy_q       <= (state_d == S_LOAD) || (state_d == S_COUNT) || (state_d == S_FEED);
      done_q       <= (state_d == S_DONE);
      fault_q      <= (state_d == S_FAULT);
    end
  end

  assign timer_load    = timer_load_q;
  assign timer_en      = timer_en_q;
  assign motor_on      = motor_on_q;
  assign portions_left = left_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fault         = fault_q;

endmodule

`default_nettype wire

// File: doc/feed_scheduler.md
FEED_SCHEDULER -- requirements
Module: feed_scheduler

Interface
REQ-001 The block SHALL have parameter MOTOR_MAX_CYCLES, default 32'd100_000_000, the FEED-state timeout in clk cycles (2 s at 50 MHz).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all flops clock on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a feeding job; honoured only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: cancel any job; has priority over every other input.
REQ-006 The block SHALL have port clear, input, 1 bit: leave FAULT.
REQ-007 The block SHALL have port portions_in, input, 3 bits: number of portions for the job, latched on start.
REQ-008 The block SHALL have port timer_done, input, 1 bit: single-cycle pulse from the countdown timer at expiry.
REQ-009 The block SHALL have port sensor_on, input, 1 bit: asynchronous dispense sensor.
REQ-010 The block SHALL have port timer_load, output, 1 bit: reload the timer with its initial value.
REQ-011 The block SHALL have port timer_en, output, 1 bit: timer counts while high.
REQ-012 The block SHALL have port motor_on, output, 1 bit: dispenser motor drive.
REQ-013 The block SHALL have port portions_left, output, 3 bits: portions still to dispense.
REQ-014 The block SHALL have port busy, output, 1 bit: high in LOAD, COUNT and FEED.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle job-complete pulse.
REQ-016 The block SHALL have port fault, output, 1 bit: high while in FAULT.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, COUNT, FEED, DONE and FAULT; all outputs SHALL be registered Moore decodes of the state.
REQ-018 In IDLE, start=1 with portions_in!=0 SHALL load portions_left<=portions_in and move to LOAD; start with portions_in==0 SHALL be ignored.
REQ-019 LOAD SHALL last exactly one cycle with timer_load=1, then move to COUNT.
REQ-020 COUNT SHALL hold timer_en=1 until timer_done=1, then move to FEED; timer_done in any other state SHALL be ignored.
REQ-021 sensor_on SHALL pass through a 2-flop synchronizer plus a delay flop; a rising edge is sync2=1 and delayed=0; the synchronizer SHALL run in every state.
REQ-022 FEED SHALL hold motor_on=1, clear a 32-bit cycle counter on entry, and increment it each cycle.
REQ-023 A rising sensor edge in FEED SHALL decrement portions_left; the next state SHALL be DONE if the result is 0, otherwise LOAD.
REQ-024 A sensor already high on FEED entry SHALL NOT count; only a rising edge counts.
REQ-025 If the counter reaches MOTOR_MAX_CYCLES-1 with no edge, the FSM SHALL move to FAULT with portions_left unchanged.
REQ-026 If a sensor edge and the timeout occur in the same cycle, the sensor edge SHALL win.
REQ-027 motor_on SHALL fall on the third rising clk edge after sensor_on is first sampled high.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-029 FAULT SHALL hold fault=1 and motor_on=0; clear=1 SHALL return to IDLE and set portions_left=0.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, set portions_left=0 and motor_on=0, and generate no done pulse.
REQ-031 abort and timer_done, or abort and a sensor edge, in the same cycle SHALL resolve to abort.
REQ-032 start while busy or in FAULT SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, clear the synchronizer and cycle counter, and drive timer_load=0, timer_en=0, motor_on=0, portions_left=0, busy=0, done=0 and fault=0.
REQ-034 Reset asserted mid-FEED SHALL drop motor_on asynchronously, without waiting for clk.

Verification (MOTOR_MAX_CYCLES=20)
REQ-035 start with portions_in=2, then two timer_done pulses and two sensor edges -> two LOAD pulses, portions_left 2->1->0, one done pulse, back to IDLE.
REQ-036 start with portions_in=0 -> remains IDLE; busy and timer_load stay 0.
REQ-037 start with portions_in=1, timer_done, no sensor -> motor_on for 20 cycles, then fault=1, motor_on=0, portions_left=1; clear -> IDLE, portions_left=0.
REQ-038 sensor_on held high before FEED entry -> no decrement; a low-then-high transition is required -> one decrement.
REQ-039 abort in the same cycle as timer_done during COUNT -> IDLE, motor_on never asserts, no done pulse.
REQ-040 rst_n low mid-FEED -> motor_on=0 and all outputs at reset values before the next clk edge.
